mux_8to1: RTL and testbench
===========================

Name: mux_8to1

Overview:
- 8-input, WIDTH-bit multiplexer. Input `a<sel>` drives `y` combinationally.
- A registered copy, `y_q`, is provided for timing-critical consumers.
- General-purpose datapath select block, used wherever one of eight equal-width buses is chosen by a 3-bit index.

Parameters:
- WIDTH, 3, bit width of each data input and of both outputs (legal range 1..64).

Ports:
- clk  input  1  single clock; all sequential logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- a0..a7  input  WIDTH each  data inputs; a0 is index 0 and a7 is index 7.
- sel  input  3  select index, unsigned 0..7.
- en  input  1  register-load enable for y_q.
- y  output  WIDTH  combinational mux output.
- y_q  output  WIDTH  registered mux output.
- y_q_valid  output  1  high once y_q holds a value loaded since reset.

Behaviour:
- y = a[sel], purely combinational, zero-cycle latency.
  - Any change on sel or on the selected input propagates to y in the same delta/cycle.
  - Changes on non-selected inputs never affect y.
- All 8 sel codes are legal; there is no out-of-range case and no default-to-zero path for a valid code.
- An unknown/undriven sel (e.g. before the first assignment) is not a functional case. RTL uses a full case over 0..7 with a default arm driving y = '0.
- Registered path:
  - On rising clk with rst_n=1 and en=1: y_q <= a[sel] and y_q_valid <= 1.
  - With en=0: y_q and y_q_valid hold.
  - Latency from sel/a change to y_q is 1 clk.
- Reset: asserting rst_n=0 immediately, without waiting for clk, forces y_q = 0 and y_q_valid = 0.
  - This holds even mid-operation.
  - Release is synchronous to the next clk edge: the first load occurs on the first rising edge with rst_n=1 and en=1.
  - y is unaffected by reset; it always reflects a[sel].
- If sel changes in the same cycle as en=1, y_q captures the value selected by sel as sampled at that edge.
- Widths: no extension or truncation; every data path is exactly WIDTH bits.

Optional Feature:
- Macro: MUX8_SEL_CHANGE_EN.
- Defined:
  - Adds output sel_changed (1 bit, registered).
  - The block keeps an internal 3-bit sel_prev register, reset to 0, loaded every clk edge when en=1.
  - sel_changed is high for exactly one cycle after a load edge where sel != sel_prev.
  - sel_changed resets to 0 asynchronously with rst_n.
  - The first load after reset compares against sel_prev = 0.
- Undefined: the port, sel_prev and the associated logic are absent; all other behaviour is identical.

Decomposition:
- Package mux_pkg holds:
  - localparam NUM_IN = 8 and SEL_W = 3;
  - typedef sel_t = logic [SEL_W-1:0];
  - DEFAULT_WIDTH = 3.
- One sub-module, mux_8to1_core: purely combinational WIDTH-parameterised 8:1 select producing y.
- The top level adds the y_q/y_q_valid register stage and the optional sel_changed logic.

Test Plan:
- a0..a7 = 0..7 (WIDTH=3); step sel 0→7, one step every 10 time units -> y equals sel at each step (0,1,...,7) with no clk required.
- rst_n=0 with en=1 and sel=5 -> y=5 immediately; y_q=0, y_q_valid=0. Release rst_n -> after the next rising clk, y_q=5 and y_q_valid=1.
- en=1, sel=3 for one edge, then en=0 and sel=6 for 3 edges -> y=6, y_q stays 3.
- Mid-operation reset: y_q=7 and y_q_valid=1, then pulse rst_n low between clk edges -> y_q=0 and y_q_valid=0 before the next edge.
- Non-selected input change: sel=2, toggle a4 between 0 and 7 -> y stays a2=2 and y_q unchanged. Then change a2 to 5 -> y=5 at once and y_q=5 after one enabled edge.
- With MUX8_SEL_CHANGE_EN, en=1, sel sequence 0,0,4,4,1 over 5 edges -> sel_changed = 0,0,1,0,1 (one cycle after each edge).

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants and types for the 8:1 select block.
// MUX8_SEL_CHANGE_EN selects whether the sel_changed output is built.
package mux_pkg;

  localparam int NUM_IN        = 8;
  localparam int SEL_W         = 3;
  localparam int DEFAULT_WIDTH = 3;

  typedef logic [SEL_W-1:0] sel_t;

`ifdef MUX8_SEL_CHANGE_EN
  localparam bit SEL_CHANGE_EN = 1'b1;
`else
  localparam bit SEL_CHANGE_EN = 1'b0;
`endif

endpackage

// File: rtl/mux_8to1_core.sv
// Purely combinational WIDTH-bit 8:1 select; y follows a<sel> with zero latency.
module mux_8to1_core
  import mux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] a2,
  input  logic [WIDTH-1:0] a3,
  input  logic [WIDTH-1:0] a4,
  input  logic [WIDTH-1:0] a5,
  input  logic [WIDTH-1:0] a6,
  input  logic [WIDTH-1:0] a7,
  input  sel_t             sel,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (sel)
      3'd0:    y = a0;
      3'd1:    y = a1;
      3'd2:    y = a2;
      3'd3:    y = a3;
      3'd4:    y = a4;
      3'd5:    y = a5;
      3'd6:    y = a6;
      3'd7:    y = a7;
      // only reachable with an unknown sel
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/mux_8to1.sv
// 8:1 mux with combinational y and an enable-loaded registered copy y_q (1 clk).
// MUX8_SEL_CHANGE_EN adds a registered sel_changed flag tracking sel across load edges.
module mux_8to1
  import mux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] a2,
  input  logic [WIDTH-1:0] a3,
  input  logic [WIDTH-1:0] a4,
  input  logic [WIDTH-1:0] a5,
  input  logic [WIDTH-1:0] a6,
  input  logic [WIDTH-1:0] a7,
  input  sel_t             sel,
  input  logic             en,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             y_q_valid
`ifdef MUX8_SEL_CHANGE_EN
  ,
  output logic             sel_changed
`endif
);

  logic [WIDTH-1:0] y_q_d;
  logic             y_q_valid_d;

  mux_8to1_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a0  (a0),
    .a1  (a1),
    .a2  (a2),
    .a3  (a3),
    .a4  (a4),
    .a5  (a5),
    .a6  (a6),
    .a7  (a7),
    .sel (sel),
    .y   (y)
  );

  // the register captures the same select result that drives y
  always_comb begin
    y_q_d       = y_q;
    y_q_valid_d = y_q_valid;
    if (en) begin
      y_q_d       = y;
      y_q_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q       <= '0;
      y_q_valid <= 1'b0;
    end else begin
      y_q       <= y_q_d;
      y_q_valid <= y_q_valid_d;
    end
  end

`ifdef MUX8_SEL_CHANGE_EN
  sel_t sel_prev_q;
  sel_t sel_prev_d;
  logic sel_changed_q;
  logic sel_changed_d;

  // flag is a one-cycle pulse: any edge without a load clears it
  always_comb begin
    sel_prev_d    = sel_prev_q;
    sel_changed_d = 1'b0;
    if (en) begin
      sel_prev_d    = sel;
      sel_changed_d = (sel != sel_prev_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_prev_q    <= '0;
      sel_changed_q <= 1'b0;
    end else begin
      sel_prev_q    <= sel_prev_d;
      sel_changed_q <= sel_changed_d;
    end
  end

  assign sel_changed = sel_changed_q;
`endif

endmodule

// File: tb/tb_mux_8to1.sv
// Scoreboard bench for mux_8to1: directed scenarios followed by random traffic.
module tb_mux_8to1;
  import mux_pkg::*;

  localparam int W = DEFAULT_WIDTH;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] av [8];
  sel_t         sel;
  logic         en;
  logic [W-1:0] y;
  logic [W-1:0] y_q;
  logic         y_q_valid;
`ifdef MUX8_SEL_CHANGE_EN
  logic         sel_changed;
`endif

  mux_8to1 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a0        (av[0]),
    .a1        (av[1]),
    .a2        (av[2]),
    .a3        (av[3]),
    .a4        (av[4]),
    .a5        (av[5]),
    .a6        (av[6]),
    .a7        (av[7]),
    .sel       (sel),
    .en        (en),
    .y         (y),
    .y_q       (y_q),
    .y_q_valid (y_q_valid)
`ifdef MUX8_SEL_CHANGE_EN
    ,
    .sel_changed (sel_changed)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] yq;
    logic         vld;
    logic         chg;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // reference state: what the registered outputs should hold after the next edge
  logic [W-1:0] m_yq   = '0;
  logic         m_vld  = 1'b0;
  logic         m_chg  = 1'b0;
  int           m_prev = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic e, input int s);
    if (!r) begin
      m_yq   = '0;
      m_vld  = 1'b0;
      m_chg  = 1'b0;
      m_prev = 0;
    end else if (e) begin
      m_yq   = av[s];
      m_vld  = 1'b1;
      m_chg  = (s != m_prev);
      m_prev = s;
    end else begin
      m_chg = 1'b0;
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.yq  = m_yq;
    e.vld = m_vld;
    e.chg = m_chg;
    exp_q.push_back(e);
  endtask

  // one clock of stimulus; idx < 8 also rewrites data input idx with val
  task automatic cycle(input logic r, input logic e, input int s,
                       input int idx = 8, input logic [W-1:0] val = '0);
    @(negedge clk);
    rst_n = r;
    en    = e;
    sel   = sel_t'(s);
    if (idx < 8) av[idx] = val;
    #1;
    chk("y_comb", 64'(y), 64'(av[s]));
    if (!r) begin
      chk("y_q_in_reset", 64'(y_q), 64'(0));
      chk("y_q_valid_in_reset", 64'(y_q_valid), 64'(0));
    end
    model_edge(r, e, s);
    push_exp();
  endtask

  // reset pulse strictly between edges; inputs are left as they were
  task automatic pulse_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_y_q", 64'(y_q), 64'(0));
    chk("async_rst_valid", 64'(y_q_valid), 64'(0));
    chk("y_during_rst", 64'(y), 64'(av[int'(sel)]));
    model_edge(1'b0, 1'b0, 0);
    #1 rst_n = 1'b1;
    model_edge(1'b1, en, int'(sel));
    push_exp();
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("y_q", 64'(y_q), 64'(e.yq));
      chk("y_q_valid", 64'(y_q_valid), 64'(e.vld));
`ifdef MUX8_SEL_CHANGE_EN
      chk("sel_changed", 64'(sel_changed), 64'(e.chg));
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    sel   = '0;
    for (int i = 0; i < 8; i++) av[i] = i[W-1:0];
    #1;
    chk("reset_y_q", 64'(y_q), 64'(0));
    chk("reset_y_q_valid", 64'(y_q_valid), 64'(0));

    // pure combinational sweep of every select code
    for (int s = 0; s < 8; s++) begin
      sel = sel_t'(s);
      #1 chk("y_sweep", 64'(y), 64'(s));
      #9;
    end

    // reset held across edges, then synchronous release
    cycle(1'b0, 1'b1, 5);
    cycle(1'b0, 1'b1, 5);
    cycle(1'b1, 1'b1, 5);

    // enable gating: y tracks sel, y_q holds
    cycle(1'b1, 1'b1, 3);
    cycle(1'b1, 1'b0, 6);
    cycle(1'b1, 1'b0, 6);
    cycle(1'b1, 1'b0, 6);

    // asynchronous reset mid-operation
    cycle(1'b1, 1'b1, 7);
    cycle(1'b1, 1'b0, 7);
    pulse_reset();
    cycle(1'b1, 1'b1, 7);

    // non-selected inputs are invisible; selected input is not
    cycle(1'b1, 1'b1, 2);
    cycle(1'b1, 1'b0, 2, 4, 3'(7));
    cycle(1'b1, 1'b0, 2, 4, 3'(0));
    cycle(1'b1, 1'b0, 2, 4, 3'(7));
    cycle(1'b1, 1'b0, 2, 2, 3'(5));
    cycle(1'b1, 1'b1, 2);

    // select-change tracking from a fresh reset
    cycle(1'b0, 1'b0, 0);
    cycle(1'b1, 1'b1, 0);
    cycle(1'b1, 1'b1, 0);
    cycle(1'b1, 1'b1, 4);
    cycle(1'b1, 1'b1, 4);
    cycle(1'b1, 1'b1, 1);
    cycle(1'b1, 1'b0, 1);

    for (int i = 0; i < 400; i++) begin
      logic         r;
      logic         e;
      int           s;
      int           idx;
      logic [W-1:0] val;
      r   = ($urandom_range(0, 24) != 0);
      e   = ($urandom_range(0, 3) != 0);
      s   = int'($urandom_range(0, 7));
      idx = int'($urandom_range(0, 8));
      val = W'($urandom);
      if (i % 37 == 5) pulse_reset();
      else cycle(r, e, s, idx, val);
    end

    cycle(1'b1, 1'b0, int'(sel));
    for (int k = 0; k < 5 && exp_q.size() != 0; k++) @(posedge clk);
    #3;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
